// File: rtl/fir_pkg.sv
// Shared widths and the shift/round/clamp helper
// for the fir output path.
package fir_pkg;

  localparam int IN_W_DEF  = 32;
  localparam int OUT_W_DEF = 16;

  function automatic logic signed [63:0] round_sat(
    input  logic signed [63:0] x,
    input  int                 shift,
    input  int                 out_w,
    output logic               clamped
  );
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (x + (64'sd1 <<< (shift - 1))) >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    clamped = 1'b0;
    if (r > hi) begin
      r = hi;
      clamped = 1'b1;
    end else if (r < lo) begin
      r = lo;
      clamped = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_decim_buf_if.sv
// Output stream of the decimating buffer:
// head data, valid and sink ready.
interface fir_decim_buf_if
  import fir_pkg::*;
#(
  parameter int W = OUT_W_DEF
);

  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/fir_fifo.sv
// Synchronous FIFO; a push on a full FIFO is
// accepted only when a pop frees a slot that cycle.
module fir_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [LW-1:0] cnt;
  logic          wr;
  logic          rd;

  assign full  = (cnt == LW'(DEPTH));
  assign empty = (cnt == '0);
  assign rd    = pop & ~empty;
  assign wr    = push & (~full | rd);
  assign level = cnt;
  // head reads as zero while empty so reset shows 0
  assign dout  = empty ? '0 : mem[rp];

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      if (wr & ~rd) cnt <= cnt + 1'b1;
      else if (rd & ~wr) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/fir_decim_buf.sv
// Keeps every DECIM-th fir sample, rescales it
// and buffers it toward a valid/ready sink.
module fir_decim_buf
  import fir_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int DECIM = 5,
  parameter int SHIFT = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IN_W-1:0]            in_data,
  input  logic                       in_valid,
  fir_decim_buf_if.master            out,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic                       sat
);

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [PW-1:0]    phase;
  logic             keep;
  logic [63:0]      ext;
  logic [OUT_W-1:0] scaled;
  logic             clamped;
  logic             s1_vld;
  logic [OUT_W-1:0] s1_data;
  logic             pop;
  logic             full;
  logic             empty;

  assign keep = in_valid & (phase == PW'(DECIM - 1));
  assign ext  = {{(64-IN_W){in_data[IN_W-1]}}, in_data};

  always_comb begin
    clamped = 1'b0;
    scaled  = OUT_W'(round_sat(ext, SHIFT, OUT_W, clamped));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase   <= '0;
      s1_vld  <= 1'b0;
      s1_data <= '0;
      sat     <= 1'b0;
    end else begin
      if (in_valid) phase <= keep ? '0 : phase + 1'b1;
      s1_vld <= keep;
      if (keep) s1_data <= scaled;
      sat <= sat | (keep & clamped);
    end
  end

  assign pop = out.out_valid & out.out_ready;

  // a kept result is lost only when full with no pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow <= 1'b0;
    else overflow <= overflow | (s1_vld & full & ~pop);
  end

  fir_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s1_vld),
    .din   (s1_data),
    .pop   (pop),
    .dout  (out.out_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign out.out_valid = ~empty;

endmodule

// File: doc/fir_decim_buf.md
# fir_decim_buf

Downstream stage of the `fir` filter. It takes the 32-bit FIR output stream and keeps every DECIM-th valid sample. Each kept sample is rescaled to OUT_W bits by round-half-up shift and saturation, then buffered in a small FIFO. The FIFO drives a valid/ready interface toward the sink, giving rate reduction, width reduction and backpressure absorption between the filter and the next consumer.

## Interface
- IN_W, 32, input sample width; signed two's complement; matches `fir` output `y`
- OUT_W, 16, output sample width; signed
- DECIM, 5, decimation factor; ≥1
- SHIFT, 8, right-shift applied before saturation; ≥1
- DEPTH, 4, FIFO entries; power of two, ≥2

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  IN_W  FIR output sample
- in_valid  in  1  in_data valid this cycle; no ready, upstream never stalls
- out_data  out  OUT_W  FIFO head
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  sink accepts head this cycle
- level  out  $clog2(DEPTH+1)  FIFO occupancy
- overflow  out  1  sticky: a kept sample was dropped on a full FIFO
- sat  out  1  sticky: a kept sample was saturated

## Operation
- Phase counter, 0..DECIM-1:
  - advances only on cycles with in_valid=1
  - wraps to 0 after DECIM-1
  - the sample accepted with phase==DECIM-1 is kept; all others are discarded
  - with DECIM=1, every valid sample is kept
- Scaling (stage 1, registered):
  - sign-extend in_data to IN_W+1
  - add 2^(SHIFT-1), then arithmetic shift right by SHIFT
  - clamp to [−2^(OUT_W−1), 2^(OUT_W−1)−1]
  - if clamped, set `sat` (only for kept samples)
- FIFO write (stage 2): a kept stage-1 result is pushed if level<DEPTH, or if level==DEPTH and a pop occurs the same cycle.
  - Otherwise the sample is dropped and `overflow` is set.
- Pop: out_valid & out_ready. Order is strictly FIFO.
- Push and pop in the same cycle: level is unchanged and both take effect.
- Sticky flags clear only on rst.
- Reset value of every output is 0, and all internal state clears: phase=0, stage-1 kept flag=0, FIFO pointers=0.
- Reset mid-operation discards buffered and in-flight samples. Decimation restarts: the 5th valid sample after reset release is the first kept (DECIM=5).

## Timing
- Kept sample accepted at edge n:
  - stage-1 register updated at edge n
  - FIFO written at edge n+1
  - out_valid=1 after edge n+1 if the FIFO was empty (2-cycle latency from input to visible output)
- out_data is valid whenever out_valid=1 and holds until popped.
- out_valid does not depend combinationally on out_ready.
- level updates on the same edge as each push/pop.
- overflow and sat assert after the edge at which the offending sample reaches stage 2 and stage 1 respectively.

## Structure
- Shared package `fir_pkg`:
  - default widths (IN_W, OUT_W)
  - `round_sat` function (shift, round, clamp) for reuse by later stages
- Sub-module `fir_fifo`: synchronous FIFO with DEPTH and width parameters, plus push/pop/full/empty/level.
- Top module holds:
  - phase counter
  - stage-1 register
  - sticky flags

## Test plan
Parameters for all scenarios: DECIM=5, SHIFT=8, OUT_W=16.
- Reset: assert rst mid-clock → all outputs 0 immediately; after release with no input, out_valid stays 0.
- Constant input: in_data=256, in_valid=1 for 10 cycles, out_ready=1 → exactly two outputs of value 1; first out_valid 2 edges after the 5th sample.
- Rounding per kept sample:
  - 384 → 2
  - 383 → 1
  - −384 → −1
  - −385 → −2
- Saturation: kept 0x7FFF_FFFF → 32767 with sat=1; kept 0x8000_0000 → −32768.
- Backpressure: out_ready=0, 25 valid samples → level=4, 5th kept sample dropped, overflow=1. Then out_ready=1 → first four kept values drain in order and overflow stays 1.
- Gaps and mid-reset:
  - in_valid toggling 1/0 → phase advances only on valid.
  - rst pulse after 3 valid samples → next output requires 5 fresh valid samples.
  - Full FIFO with simultaneous pop and kept push → push accepted, level stays 4.
